ph_arb: RTL and testbench

PH_ARB -- requirements
Module: ph_arb

---
 rtl/ph_arb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ph_arb.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ph_arb.sv
// ============================================================================
// Module   : ph_arb
// Purpose  : Eight-channel sample arbiter. Each channel owns a one-deep
//            holding register. Captured samples are forwarded round-robin
//            onto a single valid/ready output stream. Overflow status, a
//            saturating drop counter, the channel mask and the round-robin
//            pointer are exposed on the fx register bus.
// Ports    : clk_sys        system clock, rising edge
//            rst            synchronous active-high reset
//            ph_ring[127:0] eight 16-bit channel results, ch i at [16i+15:16i]
//            ph_vld[7:0]    per-channel single-cycle valid strobes
//            out_data[15:0] granted sample
//            out_ch[2:0]    channel index of out_data
//            out_vld        output valid
//            out_rdy        downstream ready
//            fx_waddr/fx_wr/fx_data   register write port
//            fx_raddr/fx_rd/fx_q      register read port (fx_q registered)
//            dev_id[5:0]    device select, matched against addr[21:16]
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ph_arb #(
  parameter int DROP_W = 8
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [127:0] ph_ring,
  input  logic [7:0]   ph_vld,
  output logic [15:0]  out_data,
  output logic [2:0]   out_ch,
  output logic         out_vld,
  input  logic         out_rdy,
  input  logic [21:0]  fx_waddr,
  input  logic         fx_wr,
  input  logic [7:0]   fx_data,
  input  logic         fx_rd,
  input  logic [21:0]  fx_raddr,
  output logic [7:0]   fx_q,
  input  logic [5:0]   dev_id
);

  // Register offsets
  localparam logic [7:0] c_OFF_MASK = 8'h00;
  localparam logic [7:0] c_OFF_OVF  = 8'h01;
  localparam logic [7:0] c_OFF_DROP = 8'h02;
  localparam logic [7:0] c_OFF_PTR  = 8'h03;

  localparam int         c_NCH      = 8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [7:0]        r_pend;
  logic [15:0]       r_hold [c_NCH];
  logic [2:0]        r_ptr;
  logic [15:0]       r_out_data;
  logic [2:0]        r_out_ch;
  logic              r_out_vld;
  logic [7:0]        r_mask;
  logic [7:0]        r_ovf;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [7:0]        r_fx_q;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic              w_load;
  logic              w_gnt_vld;
  logic [2:0]        w_gnt_idx;
  logic [7:0]        w_stb;
  logic [7:0]        w_take;
  logic [7:0]        w_drop;
  logic              w_any_drop;
  logic              w_wsel;
  logic              w_rsel;
  logic [7:0]        w_woff;
  logic [7:0]        w_roff;
  logic              w_wr_mask;
  logic              w_wr_ovf;
  logic              w_wr_drop;
  logic [7:0]        w_ovf_clr;
  logic              w_cnt_sat;
  logic [7:0]        w_cnt_rd;
  logic [7:0]        w_rd_val;
  logic              w_unused_addr_bits;

  // Address bits [15:8] play no part in decoding.
  assign w_unused_addr_bits = ^{fx_waddr[15:8], fx_raddr[15:8]};

  // --------------------------------------------------------------------------
  // Register bus decode
  // --------------------------------------------------------------------------
  assign w_wsel    = fx_wr & (fx_waddr[21:16] == dev_id);
  assign w_rsel    = fx_rd & (fx_raddr[21:16] == dev_id);
  assign w_woff    = fx_waddr[7:0];
  assign w_roff    = fx_raddr[7:0];
  assign w_wr_mask = w_wsel & (w_woff == c_OFF_MASK);
  assign w_wr_ovf  = w_wsel & (w_woff == c_OFF_OVF);
  assign w_wr_drop = w_wsel & (w_woff == c_OFF_DROP);
  assign w_ovf_clr = w_wr_ovf ? fx_data : 8'h00;

  // --------------------------------------------------------------------------
  // Output stage loads whenever it is empty or its current word is accepted.
  // --------------------------------------------------------------------------
  assign w_load = ~r_out_vld | out_rdy;

  // Round-robin pick: scan ptr+1 .. ptr+8 (mod 8). The loop runs from the
  // farthest candidate to the nearest, so the nearest pending channel is the
  // last assignment and therefore wins.
  always_comb begin
    logic [2:0] v_cand;
    w_gnt_vld = 1'b0;
    w_gnt_idx = 3'd0;
    v_cand    = 3'd0;
    for (int k = c_NCH; k >= 1; k--) begin
      v_cand = r_ptr + 3'(k);
      if (r_pend[v_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = v_cand;
      end
    end
  end

  // Per-channel strobe qualification. A channel taken by the output stage
  // in the same cycle frees its slot, so a coincident strobe is a capture.
  always_comb begin
    w_stb  = 8'h00;
    w_take = 8'h00;
    w_drop = 8'h00;
    for (int i = 0; i < c_NCH; i++) begin
      w_stb[i]  = ph_vld[i] & r_mask[i];
      w_take[i] = w_load & w_gnt_vld & (w_gnt_idx == 3'(i));
      w_drop[i] = w_stb[i] & r_pend[i] & ~w_take[i];
    end
  end

  assign w_any_drop = |w_drop;
  assign w_cnt_sat  = &r_drop_cnt;

  // --------------------------------------------------------------------------
  // Pending bits and holding registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_pend <= 8'h00;
      for (int i = 0; i < c_NCH; i++) begin
        r_hold[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < c_NCH; i++) begin
        if (!r_mask[i]) begin
          // A disabled channel forgets anything it was holding.
          r_pend[i] <= 1'b0;
        end else if (w_stb[i]) begin
          if (!w_drop[i]) begin
            r_pend[i] <= 1'b1;
            r_hold[i] <= ph_ring[16*i +: 16];
          end
        end else if (w_take[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_out_data <= 16'h0000;
      r_out_ch   <= 3'd0;
      r_out_vld  <= 1'b0;
      r_ptr      <= 3'd7;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_data <= r_hold[w_gnt_idx];
        r_out_ch   <= w_gnt_idx;
        r_out_vld  <= 1'b1;
        r_ptr      <= w_gnt_idx;
      end else begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_mask <= 8'hFF;
      r_ovf  <= 8'h00;
    end else begin
      if (w_wr_mask) begin
        r_mask <= fx_data;
      end
      // Write-one-to-clear; a new overflow in the same cycle stays set.
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_drop;
    end
  end

  // Drop counter counts cycles with at least one drop. A clear landing in
  // the same cycle as a drop leaves the count at one.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_any_drop) begin
      if (w_wr_drop) begin
        r_drop_cnt <= DROP_W'(1);
      end else if (!w_cnt_sat) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end else if (w_wr_drop) begin
      r_drop_cnt <= '0;
    end
  end

  generate
    if (DROP_W >= 8) begin : g_cnt_full
      assign w_cnt_rd = r_drop_cnt[7:0];
    end else begin : g_cnt_pad
      assign w_cnt_rd = {{(8 - DROP_W){1'b0}}, r_drop_cnt};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_val = 8'h00;
    case (w_roff)
      c_OFF_MASK: w_rd_val = r_mask;
      c_OFF_OVF:  w_rd_val = r_ovf;
      c_OFF_DROP: w_rd_val = w_cnt_rd;
      c_OFF_PTR:  w_rd_val = {5'b00000, r_ptr};
      default:    w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_fx_q <= 8'h00;
    end else begin
      r_fx_q <= w_rsel ? w_rd_val : 8'h00;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_data = r_out_data;
  assign out_ch   = r_out_ch;
  assign out_vld  = r_out_vld;
  assign fx_q     = r_fx_q;

endmodule

`default_nettype wire

// File: tb/tb_ph_arb.sv
// ============================================================================
// Module   : tb_ph_arb
// Purpose  : Self-checking bench for ph_arb. Directed scenarios followed by a
//            randomized run, all compared cycle by cycle against a behavioural
//            model of the arbiter kept in this file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ph_arb;

  localparam logic [5:0] c_DEV = 6'h2A;

  logic         clk_sys = 1'b0;
  logic         rst     = 1'b1;
  logic [127:0] ph_ring = '0;
  logic [7:0]   ph_vld  = 8'h00;
  logic [15:0]  out_data;
  logic [2:0]   out_ch;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [21:0]  fx_waddr = '0;
  logic         fx_wr    = 1'b0;
  logic [7:0]   fx_data  = 8'h00;
  logic         fx_rd    = 1'b0;
  logic [21:0]  fx_raddr = '0;
  logic [7:0]   fx_q;
  logic [5:0]   dev_id   = c_DEV;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  ph_arb #(.DROP_W(8)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .ph_ring  (ph_ring),
    .ph_vld   (ph_vld),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .dev_id   (dev_id)
  );

  // ---------------------------------------------------------------- model
  logic [7:0]  m_pend;
  logic [15:0] m_hold [8];
  int          m_ptr;
  logic [15:0] m_odata;
  int          m_och;
  logic        m_ovld;
  logic [7:0]  m_mask;
  logic [7:0]  m_ovf;
  int          m_drop;
  logic [7:0]  m_q;

  // One clock edge of the reference behaviour, evaluated from the inputs
  // present at the edge and the state before it.
  task automatic model_tick();
    int         g;
    int         c;
    int         woff;
    logic       wsel;
    logic [7:0] drops;
    logic [7:0] nq;
    if (rst) begin
      m_pend = 8'h00;
      for (int i = 0; i < 8; i++) m_hold[i] = 16'h0000;
      m_ptr = 7; m_odata = 16'h0000; m_och = 0; m_ovld = 1'b0;
      m_mask = 8'hFF; m_ovf = 8'h00; m_drop = 0; m_q = 8'h00;
      return;
    end
    // register read sees the pre-edge values
    nq = 8'h00;
    if (fx_rd && fx_raddr[21:16] == dev_id) begin
      case (int'(fx_raddr[7:0]))
        0: nq = m_mask;
        1: nq = m_ovf;
        2: nq = 8'(m_drop);
        3: nq = 8'(m_ptr);
        default: nq = 8'h00;
      endcase
    end
    // arbitration
    g = -1;
    if ((!m_ovld || out_rdy) && m_pend != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        c = (m_ptr + k) % 8;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (!m_ovld || out_rdy) begin
      if (g >= 0) begin
        m_odata = m_hold[g]; m_och = g; m_ovld = 1'b1; m_ptr = g;
      end else begin
        m_ovld = 1'b0;
      end
    end
    // channel capture
    drops = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (!m_mask[i]) begin
        m_pend[i] = 1'b0;
      end else if (ph_vld[i]) begin
        if (m_pend[i] && g != i) begin
          drops[i] = 1'b1;
        end else begin
          m_pend[i] = 1'b1;
          m_hold[i] = ph_ring[i*16 +: 16];
        end
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
    // register writes
    wsel = fx_wr && (fx_waddr[21:16] == dev_id);
    woff = int'(fx_waddr[7:0]);
    m_ovf = (m_ovf & ~((wsel && woff == 1) ? fx_data : 8'h00)) | drops;
    if (drops != 8'h00) begin
      if (wsel && woff == 2) m_drop = 1;
      else if (m_drop < 255) m_drop = m_drop + 1;
    end else if (wsel && woff == 2) begin
      m_drop = 0;
    end
    if (wsel && woff == 0) m_mask = fx_data;
    m_q = nq;
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model and compare every output.
  task automatic step();
    @(posedge clk_sys);
    model_tick();
    #1;
    chk("out_vld",  {31'b0, out_vld}, {31'b0, m_ovld});
    chk("out_data", {16'b0, out_data}, {16'b0, m_odata});
    chk("out_ch",   {29'b0, out_ch}, 32'(m_och));
    chk("fx_q",     {24'b0, fx_q}, {24'b0, m_q});
  endtask

  function automatic logic [21:0] fx_addr(input logic [7:0] off);
    return {c_DEV, 8'h00, off};
  endfunction

  task automatic do_reset();
    rst = 1'b1; ph_vld = 8'h00; fx_wr = 1'b0; fx_rd = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic fx_write(input logic [7:0] off, input logic [7:0] d);
    fx_waddr = fx_addr(off); fx_data = d; fx_wr = 1'b1;
    step();
    fx_wr = 1'b0;
  endtask

  task automatic fx_read(input logic [7:0] off, output logic [7:0] v);
    fx_raddr = fx_addr(off); fx_rd = 1'b1;
    step();
    v = fx_q;
    fx_rd = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] v;

    // Reset state
    do_reset();
    chk("rst_vld",  {31'b0, out_vld}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_ch",   {29'b0, out_ch}, 32'd0);
    fx_read(8'h00, v); chk("rst_mask", {24'b0, v}, 32'hFF);
    fx_read(8'h01, v); chk("rst_ovf",  {24'b0, v}, 32'h00);
    fx_read(8'h02, v); chk("rst_drop", {24'b0, v}, 32'h00);
    fx_read(8'h03, v); chk("rst_ptr",  {24'b0, v}, 32'h07);

    // Single sample, two-cycle latency
    out_rdy = 1'b1;
    ph_ring[15:0] = 16'h1234; ph_vld = 8'h01;
    step();
    ph_vld = 8'h00;
    chk("lat_n1_vld", {31'b0, out_vld}, 32'd0);
    step();
    chk("lat_n2_vld",  {31'b0, out_vld}, 32'd1);
    chk("lat_n2_data", {16'b0, out_data}, 32'h1234);
    chk("lat_n2_ch",   {29'b0, out_ch}, 32'd0);
    step();
    chk("lat_n3_vld",  {31'b0, out_vld}, 32'd0);

    // All channels at once: emitted 0..7 on consecutive cycles
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) ph_ring[i*16 +: 16] = 16'hA000 + 16'(i);
    ph_vld = 8'hFF;
    step();
    ph_vld = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_vld",  {31'b0, out_vld}, 32'd1);
      chk("rr_ch",   {29'b0, out_ch}, 32'(i));
      chk("rr_data", {16'b0, out_data}, 32'hA000 + 32'(i));
    end
    step();
    chk("rr_end_vld", {31'b0, out_vld}, 32'd0);
    fx_read(8'h03, v); chk("rr_ptr", {24'b0, v}, 32'h07);

    // Overflow on channel 3 while the output is stalled
    do_reset();
    out_rdy = 1'b0;
    ph_ring[15:0] = 16'h0B0B; ph_vld = 8'h01;
    step();
    ph_vld = 8'h00;
    step(); step();
    ph_ring[63:48] = 16'h3333; ph_vld = 8'h08;
    step();
    ph_ring[63:48] = 16'h4444; ph_vld = 8'h08;
    step();
    ph_vld = 8'h00;
    fx_read(8'h01, v); chk("ovf_set",  {24'b0, v}, 32'h08);
    fx_read(8'h02, v); chk("ovf_drop", {24'b0, v}, 32'h01);
    out_rdy = 1'b1;
    step();
    chk("ovf_kept_ch",   {29'b0, out_ch}, 32'd3);
    chk("ovf_kept_data", {16'b0, out_data}, 32'h3333);
    step();
    fx_write(8'h01, 8'h08);
    fx_read(8'h01, v); chk("ovf_w1c", {24'b0, v}, 32'h00);

    // Masked channel produces nothing
    do_reset();
    fx_write(8'h00, 8'hFE);
    out_rdy = 1'b1;
    ph_vld = 8'h01;
    step();
    ph_vld = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mask_vld", {31'b0, out_vld}, 32'd0);
    end
    fx_read(8'h01, v); chk("mask_ovf", {24'b0, v}, 32'h00);
    fx_write(8'h00, 8'hFF);

    // Back-pressure holds the output stable
    do_reset();
    out_rdy = 1'b0;
    ph_ring[95:80] = 16'h5A5A; ph_vld = 8'h20;
    step();
    ph_vld = 8'h00;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld",  {31'b0, out_vld}, 32'd1);
      chk("bp_data", {16'b0, out_data}, 32'h5A5A);
      chk("bp_ch",   {29'b0, out_ch}, 32'd5);
    end
    out_rdy = 1'b1;
    step();
    chk("bp_done_vld", {31'b0, out_vld}, 32'd0);

    // Drop counter saturation and clear
    do_reset();
    out_rdy = 1'b0;
    ph_vld = 8'h01;
    step();
    ph_vld = 8'h00;
    step(); step();
    ph_vld = 8'h02;
    step();
    for (int i = 0; i < 300; i++) step();
    ph_vld = 8'h00;
    fx_read(8'h02, v); chk("drop_sat", {24'b0, v}, 32'hFF);
    fx_write(8'h02, 8'h00);
    fx_read(8'h02, v); chk("drop_clr", {24'b0, v}, 32'h00);
    // clear coinciding with a drop leaves one
    ph_vld = 8'h02;
    fx_write(8'h02, 8'h00);
    ph_vld = 8'h00;
    fx_read(8'h02, v); chk("drop_clr_inc", {24'b0, v}, 32'h01);
    // W1C coinciding with a new overflow leaves it set
    fx_write(8'h01, 8'hFF);
    ph_vld = 8'h02;
    fx_write(8'h01, 8'hFF);
    ph_vld = 8'h00;
    fx_read(8'h01, v); chk("ovf_set_wins", {24'b0, v}, 32'h02);
    // unselected device and unmapped offsets
    fx_waddr = {c_DEV ^ 6'h01, 8'h00, 8'h00}; fx_data = 8'h00; fx_wr = 1'b1;
    step();
    fx_wr = 1'b0;
    fx_read(8'h00, v); chk("other_dev_wr", {24'b0, v}, 32'hFF);
    fx_read(8'h07, v); chk("unmapped_rd", {24'b0, v}, 32'h00);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      ph_ring = {$urandom, $urandom, $urandom, $urandom};
      ph_vld  = 8'($urandom & $urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      fx_wr   = ($urandom_range(0, 11) == 0);
      fx_waddr = {(($urandom_range(0, 3) == 0) ? 6'($urandom) : c_DEV),
                  8'($urandom), 8'($urandom_range(0, 5))};
      fx_data = 8'($urandom);
      if (fx_waddr[7:0] == 8'h00) fx_data = fx_data | 8'($urandom);
      fx_rd   = ($urandom_range(0, 3) == 0);
      fx_raddr = {(($urandom_range(0, 7) == 0) ? 6'($urandom) : c_DEV),
                  8'($urandom), 8'($urandom_range(0, 5))};
      rst = (n == 2000);
      step();
    end
    rst = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0; ph_vld = 8'h00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
